port_alloc_unsort: RTL and testbench

//  Back end of the BLESS age-sort stage. Takes the 4 rank-ordered slots from
//  the permutation network (rank 0 = oldest). Allocates output ports oldest-first.

---
 rtl/port_alloc_unsort_pkg.sv | 33 +++
 rtl/port_alloc_unsort_rr_pick.sv | 26 ++
 rtl/port_alloc_unsort.sv | 99 +++++++++
 tb/tb_port_alloc_unsort.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/port_alloc_unsort_pkg.sv
// port_alloc_unsort_pkg: shared constants, slot record and helpers for the BLESS port allocator
package port_alloc_unsort_pkg;
   localparam int NUM_PORT   = 5;
   localparam int TIME_WIDTH = 8;
   localparam int NCH        = NUM_PORT - 1;
   localparam int PERM_WIDTH = $clog2(NCH);
   localparam int CW         = $clog2(NCH + 1);
   localparam logic [PERM_WIDTH-1:0] PORT_N = 2'd0;
   localparam logic [PERM_WIDTH-1:0] PORT_E = 2'd1;
   localparam logic [PERM_WIDTH-1:0] PORT_S = 2'd2;
   localparam logic [PERM_WIDTH-1:0] PORT_W = 2'd3;
   typedef struct packed {
      logic                  vld;
      logic                  dfl;
      logic [PERM_WIDTH-1:0] port;
   } slot_t;
   function automatic logic [PERM_WIDTH-1:0] enc(input logic [NCH-1:0] oh);
      enc = '0;
      for (int i = 0; i < NCH; i++)
         if (oh[i]) enc = PERM_WIDTH'(i);
   endfunction
   function automatic logic [CW-1:0] popcnt(input logic [NCH-1:0] v);
      popcnt = '0;
      for (int i = 0; i < NCH; i++)
         popcnt = popcnt + CW'(v[i]);
   endfunction
   function automatic logic has_dup(input logic [NCH*PERM_WIDTH-1:0] d);
      has_dup = 1'b0;
      for (int i = 0; i < NCH; i++)
         for (int j = i + 1; j < NCH; j++)
            if (d[i*PERM_WIDTH +: PERM_WIDTH] == d[j*PERM_WIDTH +: PERM_WIDTH]) has_dup = 1'b1;
   endfunction
endpackage

// File: rtl/port_alloc_unsort_rr_pick.sv
// rr_pick: first available port scanning upward (mod NCH) from a start pointer
//   avail  in  NCH         ports still free
//   start  in  PERM_WIDTH  scan start position
//   grant  out NCH         one-hot chosen port (0 when none free)
//   found  out 1           some port was free
module rr_pick
   import port_alloc_unsort_pkg::*;
(
   input  logic [NCH-1:0]        avail,
   input  logic [PERM_WIDTH-1:0] start,
   output logic [NCH-1:0]        grant,
   output logic                  found
);
   logic [PERM_WIDTH-1:0] idx;
   // Scan farthest-first so the position nearest to start is written last and wins;
   // the pointer sum wraps naturally because NCH is a power of two.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = start + PERM_WIDTH'(k);
         if (avail[idx]) grant = NCH'(1) << idx;
      end
      found = |avail;
   end
endmodule

// File: rtl/port_alloc_unsort.sv
// port_alloc_unsort: oldest-first output port allocation, unsorted back to input channels
//   clk, reset              clock; asynchronous active-low reset
//   in_valid/in_ready       rank slot handshake (in_ready = !out_valid | out_ready)
//   rank_dir, rank_ppv      per-rank channel index and productive port vector, rank 0 oldest
//   flit_vld                per input channel: channel carries a flit
//   out_valid/out_ready     registered result handshake
//   out_port, out_flit_vld, out_deflect  per-channel result in input order
//   defl_cnt                saturating deflected-flit count
//   perm_err                sticky: rank_dir held a duplicate channel index
module port_alloc_unsort
   import port_alloc_unsort_pkg::*;
#(
   parameter int DCNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NCH*PERM_WIDTH-1:0] rank_dir,
   input  logic [NCH*NCH-1:0]        rank_ppv,
   input  logic [NCH-1:0]            flit_vld,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NCH*PERM_WIDTH-1:0] out_port,
   output logic [NCH-1:0]            out_flit_vld,
   output logic [NCH-1:0]            out_deflect,
   output logic [DCNT_WIDTH-1:0]     defl_cnt,
   output logic                      perm_err
);
   logic [NCH-1:0]            av   [NCH];
   logic [NCH-1:0]            pr   [NCH];
   logic [NCH-1:0]            req  [NCH];
   logic [NCH-1:0]            gnt  [NCH];
   logic [PERM_WIDTH-1:0]     st   [NCH];
   logic [PERM_WIDTH-1:0]     dir  [NCH];
   slot_t                     slot [NCH];
   logic [NCH-1:0]            fnd, sdfl;
   logic [PERM_WIDTH-1:0]     rr_ptr;
   logic [NCH*PERM_WIDTH-1:0] n_port;
   logic [NCH-1:0]            n_fv, n_df;
   logic [DCNT_WIDTH:0]       sum;
   logic                      acc;
   // One picker per rank: productive ports are taken lowest-bit-first (start 0),
   // otherwise any free port is taken round-robin from rr_ptr.
   for (genvar r = 0; r < NCH; r++) begin : g_rank
      if (r == 0) begin : g_first
         assign av[r] = '1;
      end else begin : g_next
         assign av[r] = slot[r-1].vld ? av[r-1] & ~gnt[r-1] : av[r-1];
      end
      assign dir[r]  = rank_dir[r*PERM_WIDTH +: PERM_WIDTH];
      assign pr[r]   = rank_ppv[r*NCH +: NCH] & av[r];
      assign req[r]  = |pr[r] ? pr[r] : av[r];
      assign st[r]   = |pr[r] ? '0 : rr_ptr;
      rr_pick u_pick (
         .avail (req[r]),
         .start (st[r]),
         .grant (gnt[r]),
         .found (fnd[r])
      );
      assign slot[r] = '{vld: flit_vld[dir[r]] & fnd[r], dfl: ~|pr[r], port: enc(gnt[r])};
      assign sdfl[r] = slot[r].vld & slot[r].dfl;
   end
   // Inverse permutation; ascending rank order lets the younger rank win a duplicated channel.
   always_comb begin
      n_port = '0;
      n_fv   = '0;
      n_df   = '0;
      for (int i = 0; i < NCH; i++)
         if (slot[i].vld) begin
            n_port[dir[i]*PERM_WIDTH +: PERM_WIDTH] = slot[i].port;
            n_fv[dir[i]] = 1'b1;
            n_df[dir[i]] = slot[i].dfl;
         end
   end
   assign in_ready = ~out_valid | out_ready;
   assign acc      = in_valid & in_ready;
   assign sum      = (DCNT_WIDTH+1)'(defl_cnt) + (DCNT_WIDTH+1)'(popcnt(sdfl));
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         out_valid    <= 1'b0;
         out_port     <= '0;
         out_flit_vld <= '0;
         out_deflect  <= '0;
         defl_cnt     <= '0;
         perm_err     <= 1'b0;
         rr_ptr       <= '0;
      end else begin
         if (in_ready) out_valid <= in_valid;
         if (acc) begin
            out_port     <= n_port;
            out_flit_vld <= n_fv;
            out_deflect  <= n_df;
            defl_cnt     <= sum[DCNT_WIDTH] ? '1 : sum[DCNT_WIDTH-1:0];
            rr_ptr       <= rr_ptr + PERM_WIDTH'(|sdfl);
            perm_err     <= perm_err | has_dup(rank_dir);
         end
      end
endmodule

// File: tb/tb_port_alloc_unsort.sv
// tb_port_alloc_unsort: directed vectors with a scoreboard queue and a decoupled output monitor
module tb_port_alloc_unsort;
   logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, perm_err;
   logic [7:0]  rank_dir = '0, out_port;
   logic [15:0] rank_ppv = '0, defl_cnt;
   logic [3:0]  flit_vld = '0, out_flit_vld, out_deflect;
   logic        s_in_ready, s_out_valid, s_perm_err;
   logic [7:0]  s_out_port;
   logic [3:0]  s_fv, s_df;
   logic [1:0]  s_cnt;
   typedef struct {
      logic [7:0] port;
      logic [3:0] fv;
      logic [3:0] df;
      int         cnt;
      logic       perr;
   } exp_t;
   exp_t sb[$];
   int   n_vec = 0, n_err = 0;
   always #5 clk = ~clk;
   port_alloc_unsort dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .rank_dir(rank_dir), .rank_ppv(rank_ppv), .flit_vld(flit_vld),
      .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port),
      .out_flit_vld(out_flit_vld), .out_deflect(out_deflect),
      .defl_cnt(defl_cnt), .perm_err(perm_err)
   );
   port_alloc_unsort #(.DCNT_WIDTH(2)) u_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
      .rank_dir(rank_dir), .rank_ppv(rank_ppv), .flit_vld(flit_vld),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_port(s_out_port),
      .out_flit_vld(s_fv), .out_deflect(s_df),
      .defl_cnt(s_cnt), .perm_err(s_perm_err)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, want);
      end
   endtask
   task automatic send(input logic [7:0] d, input logic [15:0] p, input logic [3:0] v,
                       input logic [7:0] e_port, input logic [3:0] e_fv, input logic [3:0] e_df,
                       input int e_cnt, input logic e_perr);
      exp_t e;
      int   t;
      t = 0;
      rank_dir = d;
      rank_ppv = p;
      flit_vld = v;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      chk("accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      e.port = e_port;
      e.fv   = e_fv;
      e.df   = e_df;
      e.cnt  = e_cnt;
      e.perr = e_perr;
      sb.push_back(e);
      in_valid = 1'b0;
   endtask
   always @(negedge clk) begin : mon
      exp_t e;
      if (reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got port %0h, expected no output", out_port);
         end else begin
            e = sb.pop_front();
            chk("out_port", 32'(out_port), 32'(e.port));
            chk("out_flit_vld", 32'(out_flit_vld), 32'(e.fv));
            chk("out_deflect", 32'(out_deflect), 32'(e.df));
            chk("defl_cnt", 32'(defl_cnt), 32'(e.cnt));
            chk("sat_cnt", 32'(s_cnt), 32'(e.cnt > 3 ? 3 : e.cnt));
            chk("perm_err", 32'(perm_err), 32'(e.perr));
         end
      end
   end
   initial begin
      int t;
      #12;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_port", 32'(out_port), 32'd0);
      chk("rst flit_vld", 32'(out_flit_vld), 32'd0);
      chk("rst deflect", 32'(out_deflect), 32'd0);
      chk("rst defl_cnt", 32'(defl_cnt), 32'd0);
      chk("rst perm_err", 32'(perm_err), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      send(8'hE4, 16'h8421, 4'hF, 8'hE4, 4'hF, 4'h0, 0, 1'b0);
      send(8'hE4, 16'h1111, 4'hF, 8'hE4, 4'hF, 4'hE, 3, 1'b0);
      send(8'h1B, 16'h4444, 4'hF, 8'h9C, 4'hF, 4'h7, 6, 1'b0);
      send(8'hE4, 16'h1111, 4'h5, 8'h20, 4'h5, 4'h4, 7, 1'b0);
      send(8'h90, 16'h1111, 4'h7, 8'h27, 4'h7, 4'h7, 10, 1'b1);
      send(8'hE4, 16'h8421, 4'hF, 8'hE4, 4'hF, 4'h0, 10, 1'b1);
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(8'hE4, 16'h1111, 4'hF, 8'hE4, 4'hF, 4'hE, 13, 1'b1);
      rank_dir = 8'h1B;
      rank_ppv = 16'h4444;
      in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("hold in_ready", 32'(in_ready), 32'd0);
         chk("hold out_valid", 32'(out_valid), 32'd1);
         chk("hold out_port", 32'(out_port), 32'hE4);
         chk("hold deflect", 32'(out_deflect), 32'hE);
         chk("hold defl_cnt", 32'(defl_cnt), 32'd13);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(8'h1B, 16'h4444, 4'hF, 8'h9C, 4'hF, 4'h7, 16, 1'b1);
      @(negedge clk);
      chk("latency out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(8'hE4, 16'h1111, 4'hF, 8'h78, 4'hF, 4'hE, 19, 1'b1);
      @(negedge clk);
      chk("held out_valid", 32'(out_valid), 32'd1);
      chk("held out_port", 32'(out_port), 32'h78);
      #2 reset = 1'b0;
      #1;
      chk("async out_valid", 32'(out_valid), 32'd0);
      chk("async out_port", 32'(out_port), 32'd0);
      chk("async flit_vld", 32'(out_flit_vld), 32'd0);
      chk("async deflect", 32'(out_deflect), 32'd0);
      chk("async defl_cnt", 32'(defl_cnt), 32'd0);
      chk("async sat_cnt", 32'(s_cnt), 32'd0);
      chk("async perm_err", 32'(perm_err), 32'd0);
      sb.delete();
      #1;
      reset = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send(8'h1B, 16'h4444, 4'hF, 8'h87, 4'hF, 4'h7, 3, 1'b0);
      t = 0;
      while (sb.size() != 0 && t < 20) begin
         t++;
         @(posedge clk);
      end
      chk("drain", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
